// File: rtl/hex_digits_ctrl.sv
// Avalon-MM controlled bank of seven-segment hex digits with blank/blink masks,
// atomic set/clear access to the nibble data and a programmable blink prescaler.
module hex_digits_ctrl #(
    parameter int                      NUM_DIGITS = 4,
    parameter int                      DIV_W      = 24,
    parameter logic [4*NUM_DIGITS-1:0] DATA_RESET = '0,
    parameter logic [DIV_W-1:0]        DIV_RESET  = DIV_W'(12500000)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [2:0]                address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic [4*NUM_DIGITS-1:0]   out_port,
    output logic [7*NUM_DIGITS-1:0]   hex_n
);

    localparam int DATA_W = 4 * NUM_DIGITS;

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_BLANK    = 3'd1,
        ADDR_BLINK    = 3'd2,
        ADDR_DIV      = 3'd3,
        ADDR_DATA_SET = 3'd4,
        ADDR_DATA_CLR = 3'd5,
        ADDR_STATUS   = 3'd6,
        ADDR_RSVD     = 3'd7
    } addr_t;

    logic [DATA_W-1:0]       r_data;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [NUM_DIGITS-1:0]   r_blink;
    logic [DIV_W-1:0]        r_div;
    logic [DIV_W-1:0]        r_cnt;
    logic                    r_phase;
    logic [7*NUM_DIGITS-1:0] r_hex;

    logic                    w_write;
    logic [7*NUM_DIGITS-1:0] w_hexNext;
    logic                    w_unused;
    addr_t                   w_addr;

    assign w_addr   = addr_t'(address);
    assign w_write  = chipselect & ~write_n;
    // Only the low bits of writedata land in registers narrower than 32 bits.
    assign w_unused = ^writedata;

    function automatic logic [6:0] segDecode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= DATA_RESET;
            r_blank <= '0;
            r_blink <= '0;
            r_div   <= DIV_RESET;
        end else if (w_write) begin
            case (w_addr)
                ADDR_DATA:     r_data  <= writedata[DATA_W-1:0];
                ADDR_BLANK:    r_blank <= writedata[NUM_DIGITS-1:0];
                ADDR_BLINK:    r_blink <= writedata[NUM_DIGITS-1:0];
                ADDR_DIV:      r_div   <= writedata[DIV_W-1:0];
                ADDR_DATA_SET: r_data  <= r_data | writedata[DATA_W-1:0];
                ADDR_DATA_CLR: r_data  <= r_data & ~writedata[DATA_W-1:0];
                default:       ;
            endcase
        end
    end

    // Reloading the divider restarts the count so a smaller divisor never has to wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_write && (w_addr == ADDR_DIV)) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_div == '0) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == r_div) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        w_hexNext = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!r_blank[i] && (!r_blink[i] || r_phase)) begin
                w_hexNext[7*i +: 7] = segDecode(r_data[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hex <= '1;
        end else begin
            r_hex <= w_hexNext;
        end
    end

    always_comb begin
        readdata = '0;
        case (w_addr)
            ADDR_DATA:   readdata = 32'(r_data);
            ADDR_BLANK:  readdata = 32'(r_blank);
            ADDR_BLINK:  readdata = 32'(r_blink);
            ADDR_DIV:    readdata = 32'(r_div);
            ADDR_STATUS: readdata = {31'd0, r_phase};
            default:     readdata = '0;
        endcase
    end

    assign out_port = r_data;
    assign hex_n    = r_hex;

endmodule

// File: tb/tb_hex_digits_ctrl.sv
// Self-checking bench for hex_digits_ctrl: register table sweep plus blink,
// blank, divider-reload and mid-operation reset sequences.
module tb_hex_digits_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] out_port;
    logic [27:0] hex_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [15:0] expOut;
        logic [27:0] expHex;
        logic [31:0] expRead;
    } vector_t;

    vector_t vectors[16];

    hex_digits_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .hex_n      (hex_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One bus write: driven on a falling edge, captured on the next rising edge.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic readRegister(input logic [2:0] addr, output logic [31:0] data);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        data       = readdata;
        chipselect = 1'b0;
    endtask

    // Divider was just reloaded with 3: phase toggles every 4 clocks, hex follows one clock later.
    task automatic blinkCheck(input logic [20:0] expUpper, input string tag);
        logic [31:0] rd;
        logic        expPhase;
        logic [6:0]  expDigit0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            expPhase  = (((j / 4) % 2) == 0);
            expDigit0 = ((((j - 1) / 4) % 2) == 0) ? 7'h00 : 7'h7F;
            readRegister(3'd6, rd);
            checkOutput($sformatf("%s status[%0d]", tag, j), rd, {31'd0, expPhase});
            checkOutput($sformatf("%s digit0[%0d]", tag, j), {25'd0, hex_n[6:0]}, {25'd0, expDigit0});
            checkOutput($sformatf("%s upper[%0d]", tag, j), {11'd0, hex_n[27:7]}, {11'd0, expUpper});
        end
    endtask

    initial begin
        logic [31:0] rd;

        vectors[0]  = '{3'd0, 32'hFFFF_A5C3, 16'hA5C3, {7'h08, 7'h12, 7'h46, 7'h30}, 32'h0000_A5C3};
        vectors[1]  = '{3'd0, 32'h0000_00F0, 16'h00F0, {7'h40, 7'h40, 7'h0E, 7'h40}, 32'h0000_00F0};
        vectors[2]  = '{3'd4, 32'hFFFF_0003, 16'h00F3, {7'h40, 7'h40, 7'h0E, 7'h30}, 32'h0000_0000};
        vectors[3]  = '{3'd5, 32'h0000_00F0, 16'h0003, {7'h40, 7'h40, 7'h40, 7'h30}, 32'h0000_0000};
        vectors[4]  = '{3'd0, 32'h0000_6789, 16'h6789, {7'h02, 7'h78, 7'h00, 7'h10}, 32'h0000_6789};
        vectors[5]  = '{3'd0, 32'h0000_BCDE, 16'hBCDE, {7'h03, 7'h46, 7'h21, 7'h06}, 32'h0000_BCDE};
        vectors[6]  = '{3'd1, 32'hFFFF_FFF5, 16'hBCDE, {7'h03, 7'h7F, 7'h21, 7'h7F}, 32'h0000_0005};
        vectors[7]  = '{3'd1, 32'h0000_0000, 16'hBCDE, {7'h03, 7'h46, 7'h21, 7'h06}, 32'h0000_0000};
        vectors[8]  = '{3'd7, 32'hFFFF_FFFF, 16'hBCDE, {7'h03, 7'h46, 7'h21, 7'h06}, 32'h0000_0000};
        vectors[9]  = '{3'd6, 32'h0000_0000, 16'hBCDE, {7'h03, 7'h46, 7'h21, 7'h06}, 32'h0000_0001};
        vectors[10] = '{3'd2, 32'h0000_000F, 16'hBCDE, {7'h03, 7'h46, 7'h21, 7'h06}, 32'h0000_000F};
        vectors[11] = '{3'd2, 32'h0000_0000, 16'hBCDE, {7'h03, 7'h46, 7'h21, 7'h06}, 32'h0000_0000};
        vectors[12] = '{3'd3, 32'h1234_5678, 16'hBCDE, {7'h03, 7'h46, 7'h21, 7'h06}, 32'h0034_5678};
        vectors[13] = '{3'd0, 32'h0000_F0A1, 16'hF0A1, {7'h0E, 7'h40, 7'h08, 7'h79}, 32'h0000_F0A1};
        vectors[14] = '{3'd5, 32'h0000_00A0, 16'hF001, {7'h0E, 7'h40, 7'h40, 7'h79}, 32'h0000_0000};
        vectors[15] = '{3'd0, 32'h0000_2345, 16'h2345, {7'h24, 7'h30, 7'h19, 7'h12}, 32'h0000_2345};

        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;

        // Power-on reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset hex_n", {4'd0, hex_n}, 32'h0FFF_FFFF);
        checkOutput("reset out_port", {16'd0, out_port}, 32'h0);
        readRegister(3'd3, rd);
        checkOutput("reset blink_div", rd, 32'h00BE_BC20);
        readRegister(3'd6, rd);
        checkOutput("reset status", rd, 32'h1);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("first decode", {4'd0, hex_n}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h40});

        // Register table sweep.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vectors[i].addr, vectors[i].wdata);
            checkOutput($sformatf("vec%0d out_port", i), {16'd0, out_port}, {16'd0, vectors[i].expOut});
            @(negedge clk);
            checkOutput($sformatf("vec%0d hex_n", i), {4'd0, hex_n}, {4'd0, vectors[i].expHex});
            readRegister(vectors[i].addr, rd);
            checkOutput($sformatf("vec%0d readdata", i), rd, vectors[i].expRead);
        end

        // Blink digit 0 with a 4-clock half period.
        applyStimulus(3'd0, 32'h0000_0008);
        applyStimulus(3'd2, 32'h0000_0001);
        applyStimulus(3'd3, 32'h0000_0003);
        blinkCheck({7'h40, 7'h40, 7'h40}, "blink");

        // Blanked digit 1 stays dark through both phases.
        applyStimulus(3'd1, 32'h0000_0002);
        applyStimulus(3'd3, 32'h0000_0003);
        blinkCheck({7'h40, 7'h40, 7'h7F}, "blank");

        // Divider reload to 0 while phase is low forces phase high and stops blinking.
        repeat (4) @(negedge clk);
        readRegister(3'd6, rd);
        checkOutput("pre-stop status", rd, 32'h0);
        applyStimulus(3'd3, 32'h0000_0000);
        readRegister(3'd6, rd);
        checkOutput("stop status", rd, 32'h1);
        checkOutput("stop digit0 lag", {25'd0, hex_n[6:0]}, {25'd0, 7'h7F});
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            readRegister(3'd6, rd);
            checkOutput($sformatf("stopped status[%0d]", j), rd, 32'h1);
            checkOutput($sformatf("stopped hex_n[%0d]", j), {4'd0, hex_n}, {4'd0, 7'h40, 7'h40, 7'h7F, 7'h00});
        end

        // Asynchronous reset in the middle of a count.
        applyStimulus(3'd3, 32'h0000_000A);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset hex_n", {4'd0, hex_n}, 32'h0FFF_FFFF);
        checkOutput("midreset out_port", {16'd0, out_port}, 32'h0);
        readRegister(3'd3, rd);
        checkOutput("midreset blink_div", rd, 32'h00BE_BC20);
        readRegister(3'd1, rd);
        checkOutput("midreset blank", rd, 32'h0);
        readRegister(3'd2, rd);
        checkOutput("midreset blink", rd, 32'h0);
        readRegister(3'd6, rd);
        checkOutput("midreset status", rd, 32'h1);
        @(negedge clk);
        checkOutput("held reset hex_n", {4'd0, hex_n}, 32'h0FFF_FFFF);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset hex_n", {4'd0, hex_n}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h40});
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            readRegister(3'd6, rd);
            checkOutput($sformatf("post-reset status[%0d]", j), rd, 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
